// File: rtl/avalon_packet_arbiter_if.sv
// Avalon-ST bundle between NUM_SOURCES sources, the packet arbiter and one shared sink.
// The master modport is the arbiter's view; slave is the view of the surrounding sources/sink.
interface avalon_packet_arbiter_if #(
  parameter int NUM_SOURCES         = 4,
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

  logic [NUM_SOURCES-1:0]                       src_valid;
  logic [NUM_SOURCES-1:0]                       src_rdy;
  logic [NUM_SOURCES-1:0]                       src_sop;
  logic [NUM_SOURCES-1:0]                       src_eop;
  logic [NUM_SOURCES*DATA_WIDTH_IN_BYTES*8-1:0] src_data;
  logic [NUM_SOURCES*EMPTY_W-1:0]               src_empty;

  logic                                         snk_valid;
  logic                                         snk_rdy;
  logic                                         snk_sop;
  logic                                         snk_eop;
  logic [DATA_WIDTH_IN_BYTES*8-1:0]             snk_data;
  logic [EMPTY_W-1:0]                           snk_empty;

  modport master (
    input  src_valid, src_sop, src_eop, src_data, src_empty, snk_rdy,
    output src_rdy, snk_valid, snk_sop, snk_eop, snk_data, snk_empty
  );

  modport slave (
    output src_valid, src_sop, src_eop, src_data, src_empty, snk_rdy,
    input  src_rdy, snk_valid, snk_sop, snk_eop, snk_data, snk_empty
  );
endinterface

// File: rtl/avalon_packet_arbiter.sv
// Packet-level round-robin arbiter: a grant is held from sop to eop, one bubble between packets.
// Optional idle watchdog on the locked source is enabled with `define AVALON_ARB_WATCHDOG_EN.
module avalon_packet_arbiter #(
  parameter int NUM_SOURCES         = 4,
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int WATCHDOG_CYCLES     = 256,
  localparam int GNT_W              = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_packet_arbiter_if.master bus,
  output logic [GNT_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 watchdog_abort
);
  localparam int DW      = DATA_WIDTH_IN_BYTES * 8;
  localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCKED = 2'd1, ABORT = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [GNT_W-1:0]   last_grant, last_grant_nxt, grant_id_nxt;
  logic [GNT_W-1:0]   winner, cand;
  logic               req_any;
  int                 scan_sum;
  logic [NUM_SOURCES-1:0] req;

  logic [DW-1:0]      data_arr  [NUM_SOURCES];
  logic [EMPTY_W-1:0] empty_arr [NUM_SOURCES];

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_unpack
    assign data_arr[i]  = bus.src_data[i*DW +: DW];
    assign empty_arr[i] = bus.src_empty[i*EMPTY_W +: EMPTY_W];
  end

  // A source may only win while presenting the first beat of a packet.
  assign req  = bus.src_valid & bus.src_sop;
  assign busy = (state != IDLE);

  always_comb begin
    req_any  = 1'b0;
    winner   = '0;
    cand     = '0;
    scan_sum = 0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      scan_sum = int'(last_grant) + k;
      if (scan_sum >= NUM_SOURCES) scan_sum = scan_sum - NUM_SOURCES;
      cand = GNT_W'(scan_sum);
      if (!req_any && req[cand]) begin
        req_any = 1'b1;
        winner  = cand;
      end
    end
  end

`ifdef AVALON_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt <= '0;
    else      idle_cnt <= idle_cnt_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GNT_W'(NUM_SOURCES - 1);
      grant_id   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_id_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    bus.src_rdy    = '0;
    bus.snk_valid  = 1'b0;
    bus.snk_sop    = 1'b0;
    bus.snk_eop    = 1'b0;
    bus.snk_data   = '0;
    bus.snk_empty  = '0;
    watchdog_abort = 1'b0;
`ifdef AVALON_ARB_WATCHDOG_EN
    idle_cnt_nxt   = '0;
`endif
    case (state)
      IDLE: begin
        if (req_any) begin
          grant_id_nxt = winner;
          state_nxt    = LOCKED;
        end
      end
      LOCKED: begin
        bus.snk_valid         = bus.src_valid[grant_id];
        bus.snk_sop           = bus.src_sop[grant_id];
        bus.snk_eop           = bus.src_eop[grant_id];
        bus.snk_data          = data_arr[grant_id];
        bus.snk_empty         = empty_arr[grant_id];
        bus.src_rdy[grant_id] = bus.snk_rdy;
        if (bus.src_valid[grant_id] && bus.snk_rdy && bus.src_eop[grant_id]) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant_id;
        end
`ifdef AVALON_ARB_WATCHDOG_EN
        else if (!bus.src_valid[grant_id]) begin
          idle_cnt_nxt = idle_cnt + 1'b1;
          if (idle_cnt_nxt == CNT_W'(WATCHDOG_CYCLES)) state_nxt = ABORT;
        end
`endif
      end
`ifdef AVALON_ARB_WATCHDOG_EN
      ABORT: begin
        // Close the stalled packet with an empty eop beat so the consumer sees a complete frame.
        bus.snk_valid = 1'b1;
        bus.snk_eop   = 1'b1;
        idle_cnt_nxt  = idle_cnt;
        if (bus.snk_rdy) begin
          watchdog_abort = 1'b1;
          last_grant_nxt = grant_id;
          state_nxt      = IDLE;
          idle_cnt_nxt   = '0;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end
endmodule
